decode_hazard_tracker: RTL and testbench
========================================

DECODE_HAZARD_TRACKER -- requirements
Module: decode_hazard_tracker

Interface
REQ-001 Parameter REG_AW, default 3: register-select width; register file holds 2**REG_AW entries.
REQ-002 Parameter DEPTH, default 3: number of pipeline slots between decode and write-back; legal range 2..8.
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-006 Port id_valid  input  1  decode stage presents a valid instruction.
REQ-007 Port rs_sel, rt_sel  input  REG_AW each  source register selects.
REQ-008 Port rs_used, rt_used  input  1 each  instruction reads rs / rt.
REQ-009 Port rd_sel  input  REG_AW  destination register.
REQ-010 Port reg_wrt  input  1  instruction writes rd_sel.
REQ-011 Port halt_req  input  1  instruction is a halt.
REQ-012 Port flush  input  1  branch/jump taken; current decode instruction is squashed.
REQ-013 Port stall  output  1  hold fetch/decode this cycle (combinational).
REQ-014 Port wb_en  output  1  write-enable for register file (oldest slot).
REQ-015 Port wb_sel  output  REG_AW  write register select (oldest slot).
REQ-016 Port halted  output  1  pipeline drained after halt.
REQ-017 Port stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-018 Block SHALL hold DEPTH slots, each {wen, rd}; slot 0 youngest, slot DEPTH-1 oldest.
REQ-019 Every cycle all slots SHALL shift one position toward DEPTH-1; slot DEPTH-1 content is discarded.
REQ-020 wb_en/wb_sel SHALL equal slot DEPTH-1 wen/rd (registered, no combinational path from inputs).
REQ-021 Slot 0 SHALL load {reg_wrt, rd_sel} when accept = id_valid & ~stall & ~flush & state==RUN; otherwise load bubble {0, 0}.
REQ-022 stall SHALL be 1 when id_valid & ~flush & state==RUN and (rs_used & rs_sel matches rd of any slot 0..DEPTH-2 with wen=1) or same for rt.
REQ-023 Slot DEPTH-1 SHALL NOT cause stall: register file bypasses same-cycle write to read.
REQ-024 flush SHALL take priority over stall; flush forces stall=0 and bubble insert.
REQ-025 Any register index, including highest (2**REG_AW-1), SHALL be tracked identically; no hard-wired register.
REQ-026 State machine: RUN, DRAIN, HALTED.
REQ-027 RUN -> DRAIN when accept & halt_req; halt instruction itself is inserted into slot 0.
REQ-028 DRAIN: accept forced 0, stall forced 0; DRAIN -> HALTED when all slots wen=0 and halt has reached slot DEPTH-1 (DEPTH cycles after entry).
REQ-029 HALTED: absorbing until rst; halted=1; only bubbles inserted.
REQ-030 stall_cnt SHALL increment by 1 each cycle stall=1; at 2**CNT_W-1 it SHALL hold (saturate, no wrap).

Reset
REQ-031 On rst=1 at clock edge: all slots {0,0}, state RUN, stall_cnt 0, halted 0, wb_en 0, wb_sel 0.
REQ-032 rst mid-DRAIN or HALTED SHALL return to RUN in one cycle with all in-flight writes discarded.
REQ-033 While rst=1, stall output SHALL be 0.

Verification
REQ-034 DEPTH=3: insert write r3, next cycle read rs=r3 -> stall=1 for 2 cycles, released when write in slot 2; wb_en=1, wb_sel=3 that cycle.
REQ-035 Write r7 followed by reads r6 with rt_used=0, rs_used=0 referencing r7 -> stall=0 throughout.
REQ-036 Hazard and flush same cycle -> stall=0, slot 0 bubble, no wb_en DEPTH cycles later.
REQ-037 halt_req accepted at cycle N with DEPTH=3 -> halted=1 from cycle N+3 onward; id_valid ignored after N.
REQ-038 CNT_W=4, force 20 stall cycles -> stall_cnt reads 15 and holds.
REQ-039 rst asserted during DRAIN -> next cycle state RUN, wb_en=0, stall_cnt=0, halted=0.

Source files
------------

// File: rtl/decode_hazard_tracker.sv
// Decode-stage hazard tracker: shadows destination registers of in-flight
// instructions, stalls on read-after-write hazards and drains the pipe on halt.
module decode_hazard_tracker #(
   parameter int REG_AW = 3,
   parameter int DEPTH  = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] rs_sel,
   input  logic [REG_AW-1:0] rt_sel,
   input  logic              rs_used,
   input  logic              rt_used,
   input  logic [REG_AW-1:0] rd_sel,
   input  logic              reg_wrt,
   input  logic              halt_req,
   input  logic              flush,
   output logic              stall,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_sel,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   localparam logic [3:0] DRAIN_LAST = 4'(DEPTH - 2);

   state_t            state;
   state_t            state_nx;
   logic              slot_wen [DEPTH];
   logic [REG_AW-1:0] slot_rd  [DEPTH];
   logic [3:0]        drain_cnt;
   logic              hazard;
   logic              pending;
   logic              accept;

   // The oldest slot is excluded from hazard detection because the register
   // file forwards its write to a same-cycle read.
   always_comb begin
      hazard  = 1'b0;
      pending = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (slot_wen[i]) begin
            pending = 1'b1;
            if ((rs_used && (rs_sel == slot_rd[i])) ||
                (rt_used && (rt_sel == slot_rd[i])))
               hazard = 1'b1;
         end
      end
      stall  = ~rst & id_valid & ~flush & (state == RUN) & hazard;
      accept = id_valid & ~stall & ~flush & (state == RUN);
   end

   always_comb begin
      state_nx = state;
      case (state)
         RUN:     if (accept && halt_req) state_nx = DRAIN;
         DRAIN:   if ((drain_cnt >= DRAIN_LAST) && !pending) state_nx = HALTED;
         HALTED:  state_nx = HALTED;
         default: state_nx = RUN;
      endcase
   end

   // Slot 0 takes the accepted instruction or a bubble; everything else
   // moves one step toward write-back and the oldest entry falls off.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_wen[i] <= 1'b0;
            slot_rd[i]  <= '0;
         end
         state     <= RUN;
         drain_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            slot_wen[i] <= slot_wen[i-1];
            slot_rd[i]  <= slot_rd[i-1];
         end
         slot_wen[0] <= accept & reg_wrt;
         slot_rd[0]  <= accept ? rd_sel : '0;
         state       <= state_nx;
         if (state != DRAIN)
            drain_cnt <= '0;
         else if (drain_cnt != 4'hF)
            drain_cnt <= drain_cnt + 4'd1;
         if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign wb_en  = slot_wen[DEPTH-1];
   assign wb_sel = slot_rd[DEPTH-1];
   assign halted = (state == HALTED);

endmodule

// File: tb/tb_decode_hazard_tracker.sv
// Directed bench for decode_hazard_tracker: expected write-backs go through a
// scoreboard queue that is DEPTH entries deep, matching the pipeline latency.
module tb_decode_hazard_tracker;

   localparam int REG_AW = 3;
   localparam int DEPTH  = 3;
   localparam int CNT_W  = 4;

   typedef struct packed {
      logic             en;
      logic [REG_AW-1:0] sel;
   } wb_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              id_valid = 1'b0;
   logic [REG_AW-1:0] rs_sel = '0;
   logic [REG_AW-1:0] rt_sel = '0;
   logic              rs_used = 1'b0;
   logic              rt_used = 1'b0;
   logic [REG_AW-1:0] rd_sel = '0;
   logic              reg_wrt = 1'b0;
   logic              halt_req = 1'b0;
   logic              flush = 1'b0;
   logic              stall;
   logic              wb_en;
   logic [REG_AW-1:0] wb_sel;
   logic              halted;
   logic [CNT_W-1:0]  stall_cnt;

   int  checks = 0;
   int  errors = 0;
   int  exp_cnt = 0;
   int  halt_age = -1;
   bit  exp_run = 1'b1;
   wb_t q[$];

   decode_hazard_tracker #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .rs_sel(rs_sel), .rt_sel(rt_sel), .rs_used(rs_used), .rt_used(rt_used),
      .rd_sel(rd_sel), .reg_wrt(reg_wrt), .halt_req(halt_req), .flush(flush),
      .stall(stall), .wb_en(wb_en), .wb_sel(wb_sel), .halted(halted),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One decode cycle: drive at the falling edge, check just after, and
   // queue what the slot-0 load should be so it can be compared DEPTH cycles on.
   task automatic applyStimulus(input logic v, input logic [2:0] rs, input logic rsu,
                                input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                                input logic wrt, input logic hlt, input logic fl,
                                input logic exp_stall);
      wb_t e;
      logic acc;
      @(negedge clk);
      id_valid = v; rs_sel = rs; rs_used = rsu; rt_sel = rt; rt_used = rtu;
      rd_sel = rd; reg_wrt = wrt; halt_req = hlt; flush = fl;
      #1;
      if (halt_age >= 0) halt_age++;
      checkOutput("stall", 32'(stall), 32'(exp_stall));
      checkOutput("halted", 32'(halted), 32'(halt_age >= DEPTH));
      e = q.pop_front();
      checkOutput("wb_en", 32'(wb_en), 32'(e.en));
      checkOutput("wb_sel", 32'(wb_sel), 32'(e.sel));
      checkOutput("stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
      acc = exp_run & v & ~fl & ~exp_stall;
      e.en  = acc & wrt;
      e.sel = acc ? rd : 3'd0;
      q.push_back(e);
      if (exp_stall && exp_cnt < 15) exp_cnt++;
      if (acc && hlt) begin
         exp_run  = 1'b0;
         halt_age = 0;
      end
   endtask

   // Holds reset for one edge while presenting a decode read, then checks
   // the cleared state once reset is released.
   task automatic resetDut(input logic v, input logic [2:0] rs, input logic rsu);
      @(negedge clk);
      rst = 1'b1;
      id_valid = v; rs_sel = rs; rs_used = rsu; rt_sel = 3'd0; rt_used = 1'b0;
      rd_sel = 3'd0; reg_wrt = 1'b0; halt_req = 1'b0; flush = 1'b0;
      #1;
      checkOutput("stall_in_rst", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      id_valid = 1'b0; rs_used = 1'b0;
      #1;
      checkOutput("rst_wb_en", 32'(wb_en), 32'd0);
      checkOutput("rst_wb_sel", 32'(wb_sel), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      q.delete();
      for (int i = 0; i < DEPTH; i++) q.push_back('0);
      exp_cnt  = 0;
      exp_run  = 1'b1;
      halt_age = -1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetDut(1'b0, 3'd0, 1'b0);

      // write r3 then read it: two stall cycles, release as r3 writes back
      applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);

      // r7 written, unused or different source selects never stall
      applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      applyStimulus(1, 6, 1, 7, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 7, 0, 7, 0, 0, 0, 0, 0, 0);
      // highest register is tracked like any other
      applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);

      // rt hazard, then flush in the same cycle as the hazard
      applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 2, 1, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 2, 1, 1, 1, 0, 1, 0);
      applyStimulus(1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // accumulate more than 15 stall cycles to saturate the 4-bit counter
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
         applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
         applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
         applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("cnt_saturated", 32'(stall_cnt), 32'd15);

      // halt with a write in flight; later instructions are ignored
      applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int k = 0; k < 6; k++)
         applyStimulus(1, 5, 1, 0, 0, 4, 1, 0, 0, 0);

      // reset out of HALTED, then halt again and reset mid-drain
      resetDut(1'b0, 3'd0, 1'b0);
      applyStimulus(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      resetDut(1'b0, 3'd0, 1'b0);
      applyStimulus(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
      applyStimulus(1, 6, 1, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 6, 1, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);

      // stall must stay low while reset is held, even with a live hazard
      applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      resetDut(1'b1, 3'd5, 1'b1);
      applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
